change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
Downstream stage of the vending machine. Takes the change amount the machine produces at the end of a transaction and pays it out one coin at a time to a coin hopper. Uses greedy selection with the denominations 50, 10, 5 and 1. Handshakes with the hopper per coin, reports progress, and latches a fault if the hopper stalls.

Parameters:
- ACK_TIMEOUT, 16: max cycles coin_req may stay high without coin_ack before FAULT.
- INIT_STOCK, 8: per-denomination coin count loaded at reset. Used only with COIN_INVENTORY_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- change_in  in  6  change amount (0..63) from the vending machine.
- change_valid  in  1  one-cycle strobe qualifying change_in.
- coin_ack  in  1  hopper has dropped the requested coin.
- coin_req  out  1  request one coin of type coin_sel.
- coin_sel  out  2  coin type: 0=1, 1=5, 2=10, 3=50.
- busy  out  1  payout in progress; new strobes are ignored.
- done  out  1  one-cycle pulse when payout completes.
- fault  out  1  sticky: hopper timeout, or (with feature) cannot make change.
- remaining  out  6  amount still owed.

Behaviour:
- Clock and reset:
  - One clock, clk. rst is synchronous and active-high.
  - All state updates on the rising edge of clk.
- Reset values: state=IDLE, coin_req=0, coin_sel=0, busy=0, done=0, fault=0, remaining=0, timeout counter=0.
- States: IDLE, SELECT, REQ, DONE, FAULT.
- IDLE:
  - change_valid=1 with change_in!=0: capture remaining<=change_in, busy<=1, go to SELECT.
  - change_valid=1 with change_in==0: ignored, no done pulse.
- SELECT (1 cycle):
  - coin_sel<= largest denomination <= remaining.
  - coin_req<=1, clear timeout counter, go to REQ.
  - First coin_req is therefore high 2 cycles after the strobe edge.
- REQ:
  - coin_req and coin_sel stay stable until coin_ack is sampled high.
  - On ack: remaining<=remaining-value(coin_sel), coin_req<=0.
  - After ack: go to DONE if the new remaining is 0, else SELECT. coin_req is low for at least 1 cycle between coins.
  - No ack: counter increments each cycle. Reaching ACK_TIMEOUT goes to FAULT.
- DONE: done=1 for exactly 1 cycle, busy<=0, go to IDLE.
- FAULT:
  - coin_req=0, busy=1, fault=1, remaining frozen.
  - Only rst exits FAULT.
- change_valid while busy: ignored; the captured amount is not altered.
- coin_ack outside REQ: ignored.
- rst mid-payout: outstanding remaining is discarded; no done pulse.
- Arithmetic:
  - 6-bit unsigned throughout.
  - Greedy selection guarantees value(coin_sel)<=remaining, so no underflow.

Optional Feature:
- Macro: COIN_INVENTORY_EN.
- With the macro defined:
  - Four 4-bit stock counters, each loaded with INIT_STOCK on rst and decremented on each ack of that type.
  - SELECT skips denominations with zero stock.
  - If remaining>0 and no stocked coin <= remaining exists, go to FAULT.
  - Extra output port stock_empty[3:0], bit i=1 when the stock of coin type i is 0.
- Without the macro: unlimited stock, no stock_empty port, no stock counters.

Decomposition:
- Package vm_pkg holds:
  - coin_t enum (COIN_1, COIN_5, COIN_10, COIN_50).
  - COIN_VAL constant array {1,5,10,50}.
  - disp_state_t enum.
- One sub-module, coin_select: combinational greedy chooser.
  - Inputs: remaining[5:0], avail[3:0].
  - Outputs: coin_sel, none_fits.
  - avail is tied to all-ones when COIN_INVENTORY_EN is not defined.

Test Plan:
- Strobe change_in=37, hopper acks 2 cycles after each req -> coins 10,10,10,5,1,1; done pulse once; remaining=0; busy low after done.
- change_in=63 -> coins 50,10,1,1,1; change_in=0 strobe -> no activity, no done.
- Second strobe change_in=20 during a payout of 15 -> ignored; only coins 10,5 dispensed.
- coin_ack held low with ACK_TIMEOUT=16 on change_in=5 -> fault=1 after 16 cycles in REQ; remaining=5; coin_req=0; rst clears all outputs.
- rst asserted between 2nd and 3rd coin of change_in=37 -> next cycle all outputs at reset values; no done pulse.
- COIN_INVENTORY_EN, INIT_STOCK=8, stock of 10s drained by 8 acks -> change_in=20 pays 5,5,5,5; then with 5s and 1s exhausted, change_in=3 -> fault, remaining=3.

Source files
------------

// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared coin types, coin values and payout FSM states
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_1  = 2'd0,
    COIN_5  = 2'd1,
    COIN_10 = 2'd2,
    COIN_50 = 2'd3
  } coin_t;

  localparam logic [5:0] COIN_VAL [4] = '{6'd1, 6'd5, 6'd10, 6'd50};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    REQ    = 3'd2,
    DONE   = 3'd3,
    FAULT  = 3'd4
  } disp_state_t;

endpackage

// File: rtl/coin_select.sv
// rtl/coin_select.sv - combinational greedy chooser of the largest available coin <= remaining
module coin_select
  import vm_pkg::*;
(
  input  logic [5:0] remaining,
  input  logic [3:0] avail,
  output logic [1:0] coin_sel,
  output logic       none_fits
);

  // Ascending scan: the last match is the largest usable denomination.
  always_comb begin
    coin_sel  = 2'(COIN_1);
    none_fits = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (avail[i] && (remaining >= COIN_VAL[i])) begin
        coin_sel  = 2'(i);
        none_fits = 1'b0;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays change one coin per hopper handshake, sticky fault on stall
// COIN_INVENTORY_EN adds per-denomination stock counters and the stock_empty port.
module change_dispenser
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
`ifdef COIN_INVENTORY_EN
  ,
  parameter int INIT_STOCK = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] change_in,
  input  logic       change_valid,
  input  logic       coin_ack,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [5:0] remaining
`ifdef COIN_INVENTORY_EN
  ,
  output logic [3:0] stock_empty
`endif
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  disp_state_t   state_q, state_d;
  logic          coin_req_q, coin_req_d;
  logic [1:0]    coin_sel_q, coin_sel_d;
  logic [5:0]    remaining_q, remaining_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    avail;
  logic [1:0]    pick;
  logic          none_fits;
  logic [5:0]    rem_after;

`ifdef COIN_INVENTORY_EN
  logic [3:0] stock_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stock_q[i] <= 4'(INIT_STOCK);
    end else if ((state_q == REQ) && coin_ack) begin
      stock_q[coin_sel_q] <= stock_q[coin_sel_q] - 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) avail[i] = (stock_q[i] != 4'd0);
  end

  assign stock_empty = ~avail;
`else
  assign avail = 4'hF;
`endif

  coin_select u_coin_select (
    .remaining (remaining_q),
    .avail     (avail),
    .coin_sel  (pick),
    .none_fits (none_fits)
  );

  assign rem_after = remaining_q - COIN_VAL[coin_sel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      coin_req_q  <= 1'b0;
      coin_sel_q  <= 2'd0;
      remaining_q <= 6'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      coin_req_q  <= coin_req_d;
      coin_sel_q  <= coin_sel_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    coin_req_d  = coin_req_q;
    coin_sel_d  = coin_sel_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (change_valid && (change_in != 6'd0)) begin
          remaining_d = change_in;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (none_fits) begin
          state_d = FAULT;
        end else begin
          coin_sel_d = pick;
          coin_req_d = 1'b1;
          cnt_d      = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        // An ack on the final allowed cycle still counts as a good drop.
        if (coin_ack) begin
          remaining_d = rem_after;
          coin_req_d  = 1'b0;
          state_d     = (rem_after == 6'd0) ? DONE : SELECT;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          coin_req_d = 1'b0;
          state_d    = FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   coin_req_d = 1'b0;
      default: state_d = IDLE;
    endcase
  end

  assign coin_req  = coin_req_q;
  assign coin_sel  = coin_sel_q;
  assign remaining = remaining_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fault     = (state_q == FAULT);

endmodule
